// File: rtl/zoom_pkg.sv
// Shared definitions for the zoom controller and the zoom ALU:
// FSM state encoding, supported zoom op codes and frame geometry.
package zoom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } zoom_state_t;

    localparam logic [2:0] OP_NORMAL   = 3'b000;
    localparam logic [2:0] OP_ZOOM_IN  = 3'b010;
    localparam logic [2:0] OP_ZOOM_OUT = 3'b100;

    localparam int IMG_W_DEF = 320;
    localparam int IMG_H_DEF = 240;
    localparam int NUM_PIX   = IMG_W_DEF * IMG_H_DEF;   // 76800
    // Width of every pixel address (source RAM, frame buffer, ALU result).
    localparam int ADDR_W    = $clog2(NUM_PIX);         // 17

    function automatic logic op_supported(input logic [2:0] op);
        return (op == OP_NORMAL) || (op == OP_ZOOM_IN) || (op == OP_ZOOM_OUT);
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Raster scan position: column, row and linear pixel index.
// The index is kept by increment alongside col/row so no multiplier is needed.
module scan_counter
    import zoom_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              advance,
    output logic [9:0]        col,
    output logic [9:0]        row,
    output logic [ADDR_W-1:0] index,
    output logic              last
);

    localparam logic [9:0] COL_MAX = 10'(IMG_W - 1);
    localparam logic [9:0] ROW_MAX = 10'(IMG_H - 1);

    // Last pixel of the frame.
    assign last = (col == COL_MAX) && (row == ROW_MAX);

    // Scan position update; wraps back to the origin after the last pixel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col   <= '0;
            row   <= '0;
            index <= '0;
        end else if (clear || (advance && last)) begin
            col   <= '0;
            row   <= '0;
            index <= '0;
        end else if (advance) begin
            index <= index + 1'b1;
            if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/zoom_ctrl.sv
// Zoom frame controller: scans the output frame, asks the zoom ALU for the
// source address of each pixel, reads the source RAM and writes the frame
// buffer. Optional macro ZOOM_CTRL_ABORT_EN adds an abort input that ends
// the frame early through DONE.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; op latched and scan cleared on acceptance
// ISSUE   | screen coords to ALU, wait for result, issue RAM read if in range
// CAPTURE | register RAM data (or fill colour for out-of-range source)
// WRITE   | one frame-buffer write, advance scan position
// DONE    | one-cycle done pulse, back to IDLE
module zoom_ctrl
    import zoom_pkg::*;
#(
    parameter int              H_START    = 160,
    parameter int              V_START    = 120,
    parameter int              IMG_W      = IMG_W_DEF,
    parameter int              IMG_H      = IMG_H_DEF,
    parameter int              PIX_W      = 8,
    parameter logic [PIX_W-1:0] FILL_COLOR = PIX_W'(8'h00)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        op_req,
    output logic              busy,
    output logic              done,
    output logic              op_err,
    output logic [9:0]        ula_x,
    output logic [9:0]        ula_y,
    output logic [2:0]        ula_op,
    input  logic              ula_zoom_done,
    input  logic [ADDR_W-1:0] ula_address,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [PIX_W-1:0]  fb_wr_data
`ifdef ZOOM_CTRL_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam logic [ADDR_W-1:0] PIX_LIMIT = ADDR_W'(IMG_W * IMG_H);

    zoom_state_t       state_q, state_d;
    logic [2:0]        op_q;
    logic              op_err_q;
    logic              in_range_q;
    logic [PIX_W-1:0]  cap_q;

    logic [9:0]        col, row;
    logic [ADDR_W-1:0] index;
    logic              last;
    logic              start_acc;
    logic              scan_adv;
    logic              addr_ok;
    logic              abort_hit;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign addr_ok   = (ula_address < PIX_LIMIT);
    assign op_err    = op_err_q;

`ifdef ZOOM_CTRL_ABORT_EN
    assign abort_hit = abort && ((state_q == ST_ISSUE) || (state_q == ST_CAPTURE) ||
                                 (state_q == ST_WRITE));
`else
    assign abort_hit = 1'b0;
`endif

    scan_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_scan (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start_acc),
        .advance (scan_adv),
        .col     (col),
        .row     (row),
        .index   (index),
        .last    (last)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Op latch, in-range flag and captured pixel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= OP_NORMAL;
            op_err_q   <= 1'b0;
            in_range_q <= 1'b0;
            cap_q      <= '0;
        end else begin
            if (start_acc) begin
                // Unsupported ops fall back to a plain copy and are flagged.
                op_q     <= op_supported(op_req) ? op_req : OP_NORMAL;
                op_err_q <= !op_supported(op_req);
            end
            if ((state_q == ST_ISSUE) && ula_zoom_done)
                in_range_q <= addr_ok;
            if (state_q == ST_CAPTURE)
                cap_q <= in_range_q ? mem_rd_data : FILL_COLOR;
        end
    end

    // Next-state and output decode; all outputs are zero while idle.
    always_comb begin
        state_d     = state_q;
        busy        = 1'b1;
        done        = 1'b0;
        ula_x       = '0;
        ula_y       = '0;
        ula_op      = '0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        fb_wr_en    = 1'b0;
        fb_wr_addr  = '0;
        fb_wr_data  = '0;
        scan_adv    = 1'b0;

        if (state_q != ST_IDLE) begin
            ula_x  = 10'(H_START) + col;
            ula_y  = 10'(V_START) + row;
            ula_op = op_q;
        end

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (abort_hit) begin
                    state_d = ST_DONE;
                end else if (ula_zoom_done) begin
                    if (addr_ok) begin
                        mem_rd_en   = 1'b1;
                        mem_rd_addr = ula_address;
                    end
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = abort_hit ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                if (abort_hit) begin
                    state_d = ST_DONE;
                end else begin
                    fb_wr_en   = 1'b1;
                    fb_wr_addr = index;
                    fb_wr_data = cap_q;
                    scan_adv   = 1'b1;
                    state_d    = last ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_zoom_ctrl.sv
// Scoreboard bench for zoom_ctrl on a reduced 32x24 frame so full frames stay
// short. A behavioural zoom ALU and source RAM sit around the DUT; expected
// frame-buffer writes are queued at frame start and popped as writes appear.
// Zoom-in maps pixel (c,r) to source (c/2+W/4, r/2+W/4), the reduced analogue
// of 80*320+80 for pixel 0 at full size.
module tb_zoom_ctrl;
    import zoom_pkg::*;

    localparam int         W    = 32;
    localparam int         H    = 24;
    localparam int         N    = W * H;
    localparam logic [7:0] FILL = 8'hA5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op_req = 3'b000;
    logic        busy, done, op_err;
    logic [9:0]  ula_x, ula_y;
    logic [2:0]  ula_op;
    logic        ula_zoom_done = 1'b1;
    logic [16:0] ula_address;
    logic        mem_rd_en;
    logic [16:0] mem_rd_addr;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        fb_wr_en;
    logic [16:0] fb_wr_addr;
    logic [7:0]  fb_wr_data;

    zoom_ctrl #(
        .IMG_W      (W),
        .IMG_H      (H),
        .FILL_COLOR (FILL)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .op_req        (op_req),
        .busy          (busy),
        .done          (done),
        .op_err        (op_err),
        .ula_x         (ula_x),
        .ula_y         (ula_y),
        .ula_op        (ula_op),
        .ula_zoom_done (ula_zoom_done),
        .ula_address   (ula_address),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .fb_wr_en      (fb_wr_en),
        .fb_wr_addr    (fb_wr_addr),
        .fb_wr_data    (fb_wr_data)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [16:0] src_addr(input int col, input int row, input logic [2:0] op);
        int sx, sy;
        case (op)
            OP_ZOOM_IN:  begin sx = col / 2 + W / 4;  sy = row / 2 + W / 4;  end
            OP_ZOOM_OUT: begin sx = 2 * col - W / 2;  sy = 2 * row - H / 2;  end
            default:     begin sx = col;              sy = row;              end
        endcase
        if (sx < 0 || sx >= W || sy < 0 || sy >= H) return 17'h1FFFF;
        return 17'(sy * W + sx);
    endfunction

    function automatic logic [7:0] ram_byte(input logic [16:0] a);
        return 8'(a[7:0] * 8'd7 + a[15:8] + 8'd3);
    endfunction

    // Behavioural zoom ALU (always ready unless the bench stalls it) and RAM.
    assign ula_address = src_addr(int'(ula_x) - 160, int'(ula_y) - 120, ula_op);

    always @(posedge clock) if (mem_rd_en) mem_rd_data <= ram_byte(mem_rd_addr);

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t sb[$];
    int  rd_cnt = 0, busy_cnt = 0, done_cnt = 0;

    // Monitor: pop expected writes, count reads, busy cycles and done pulses.
    always @(negedge clock) begin
        wr_t e;
        if (mem_rd_en) rd_cnt++;
        if (busy)      busy_cnt++;
        if (done)      done_cnt++;
        if (fb_wr_en) begin
            if (sb.size() == 0) begin
                expect_eq("sb_unexpected_write", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                expect_eq("wr_addr", 32'(fb_wr_addr), 32'(e.addr));
                expect_eq("wr_data", 32'(fb_wr_data), 32'(e.data));
            end
        end
    end

    task automatic push_frame(input logic [2:0] eff_op, output int exp_rd);
        wr_t e;
        logic [16:0] a;
        sb.delete();
        exp_rd = 0;
        for (int i = 0; i < N; i++) begin
            a = src_addr(i % W, i / W, eff_op);
            e.addr = 17'(i);
            if (a < 17'(N)) begin
                e.data = ram_byte(a);
                exp_rd++;
            end else begin
                e.data = FILL;
            end
            sb.push_back(e);
        end
    endtask

    // Returns at the negedge of the first ISSUE cycle.
    task automatic start_frame(input logic [2:0] op);
        @(negedge clock);
        op_req   = op;
        start    = 1'b1;
        busy_cnt = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (done) begin seen = 1; break; end
        end
        expect_eq("done_seen", 32'(seen), 32'd1);
        @(negedge clock);
        expect_eq("idle_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    task automatic wait_write(input int idx, input int budget);
        bit seen = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (fb_wr_en && fb_wr_addr == 17'(idx)) begin seen = 1; break; end
        end
        expect_eq("write_seen", 32'(seen), 32'd1);
    endtask

    task automatic frame_tail(input int exp_busy, input int exp_rd);
        expect_eq("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        expect_eq("done_pulses", 32'(done_cnt), 32'd1);
        expect_eq("rd_count",    32'(rd_cnt),   32'(exp_rd));
        expect_eq("sb_drained",  32'(sb.size()), 32'd0);
    endtask

    initial begin
        int exp_rd;
        int got;

        // Reset values.
        repeat (3) @(negedge clock);
        expect_eq("rst_status", {29'd0, busy, done, op_err}, 32'd0);
        expect_eq("rst_ula",    {9'd0, ula_x, ula_y, ula_op}, 32'd0);
        expect_eq("rst_rd",     {14'd0, mem_rd_en, mem_rd_addr}, 32'd0);
        expect_eq("rst_wr",     {6'd0, fb_wr_en, fb_wr_addr, fb_wr_data}, 32'd0);
        reset_n = 1'b1;

        // Normal copy.
        push_frame(OP_NORMAL, exp_rd);
        start_frame(OP_NORMAL);
        expect_eq("n_ula_x",   32'(ula_x), 32'd160);
        expect_eq("n_ula_y",   32'(ula_y), 32'd120);
        expect_eq("n_ula_op",  32'(ula_op), 32'(OP_NORMAL));
        expect_eq("n_busy",    32'(busy), 32'd1);
        expect_eq("n_rd",      {15'd0, mem_rd_en, mem_rd_addr}, {15'd0, 1'b1, 17'd0});
        wait_done(4 * N + 50);
        frame_tail(3 * N + 1, exp_rd);

        // Zoom-in.
        push_frame(OP_ZOOM_IN, exp_rd);
        start_frame(OP_ZOOM_IN);
        expect_eq("zi_ula_op", 32'(ula_op), 32'(OP_ZOOM_IN));
        expect_eq("zi_rd",     {15'd0, mem_rd_en, mem_rd_addr}, {15'd0, 1'b1, 17'(8 * W + 8)});
        wait_done(4 * N + 50);
        frame_tail(3 * N + 1, exp_rd);

        // Zoom-out: pixel 0 has no source, so no read and fill colour.
        push_frame(OP_ZOOM_OUT, exp_rd);
        start_frame(OP_ZOOM_OUT);
        expect_eq("zo_rd",     {15'd0, mem_rd_en, mem_rd_addr}, 32'd0);
        wait_done(4 * N + 50);
        frame_tail(3 * N + 1, exp_rd);

        // Unsupported op, plus a start pulse mid-frame that must be ignored.
        push_frame(OP_NORMAL, exp_rd);
        start_frame(3'b111);
        expect_eq("bad_op_err", 32'(op_err), 32'd1);
        expect_eq("bad_ula_op", 32'(ula_op), 32'(OP_NORMAL));
        wait_write(5, 100);
        op_req = OP_ZOOM_IN;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        expect_eq("bad_op_hold", 32'(ula_op), 32'(OP_NORMAL));
        wait_done(4 * N + 50);
        frame_tail(3 * N + 1, exp_rd);
        expect_eq("op_err_sticky", 32'(op_err), 32'd1);

        // ALU stall of 5 cycles at pixel 10.
        push_frame(OP_NORMAL, exp_rd);
        start_frame(OP_NORMAL);
        expect_eq("op_err_clear", 32'(op_err), 32'd0);
        wait_write(9, 100);
        ula_zoom_done = 1'b0;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k <= 5) expect_eq("stall_quiet", {30'd0, mem_rd_en, fb_wr_en}, 32'd0);
            if (fb_wr_en) begin got = k; break; end
            if (k == 6) ula_zoom_done = 1'b1;
        end
        ula_zoom_done = 1'b1;
        expect_eq("stall_latency", 32'(got), 32'd8);
        wait_done(4 * N + 50);
        frame_tail(3 * N + 6, exp_rd);

        // Reset in the middle of a frame.
        push_frame(OP_NORMAL, exp_rd);
        start_frame(OP_NORMAL);
        wait_write(100, 400);
        #1 reset_n = 1'b0;
        #1;
        expect_eq("mid_rst_status", {29'd0, busy, done, fb_wr_en}, 32'd0);
        expect_eq("mid_rst_out",    {5'd0, mem_rd_en, ula_x, fb_wr_addr}, 32'd0);
        sb.delete();
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        expect_eq("mid_rst_no_done", 32'(done_cnt), 32'd0);

        // Fresh frame after reset rescans from index 0.
        push_frame(OP_NORMAL, exp_rd);
        start_frame(OP_NORMAL);
        expect_eq("re_ula_xy", {12'd0, ula_x, ula_y}, {12'd0, 10'd160, 10'd120});
        wait_done(4 * N + 50);
        frame_tail(3 * N + 1, exp_rd);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
